ps2_scancode_receiver: RTL and testbench
========================================

Name: ps2_scancode_receiver

Overview:
- Front end of the keyboard path: deserialises the PS/2 device-to-host stream into 8-bit scan codes.
- Drives the scan-code byte consumed by the paddle/bar movement logic.
- Also maintains a "currently held key" code:
  - set on a make code;
  - cleared to 0x00 on the matching break sequence (F0 xx).
  - Downstream logic can therefore compare against 0x1D / 0x1B continuously.
- Sits in the clk domain; PS/2 pins are asynchronous inputs.

Parameters:
FILTER_LEN, 8, consecutive clk cycles the synchronised ps2_clk must hold a new level before the filtered clock changes
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
byte_out  output  8  last accepted raw byte (any code, including F0/E0)
byte_valid  output  1  one-cycle pulse when byte_out updates
key_code  output  8  held make code; 0x00 when no key is held
frame_error  output  1  one-cycle pulse on a rejected or aborted frame

Behaviour:
- Synchronisation and filtering:
  - ps2_clk and ps2_data each pass through 2 flops.
  - Filtered clock resets to 1. It takes the synchronised level only after FILTER_LEN consecutive equal samples that differ from the current filtered value.
  - Falling edge (fe) = filtered clock was 1 on the previous cycle and is 0 now.
  - Data is sampled from the synchronised ps2_data in the fe cycle.
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1). 11 fe per frame.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe, sampled 0 → DATA, bit_cnt=0. Sampled 1 → frame_error pulse, stay IDLE.
  - DATA: on fe, shift the sampled bit into bit position bit_cnt and increment bit_cnt. After the 8th bit → PARITY.
  - PARITY: on fe, latch the parity bit → STOP.
  - STOP: on fe, sampled 1 → accept (parity rule below). Sampled 0 → frame_error, discard. Both cases → IDLE.
- Timeout:
  - An idle counter resets on every fe and counts only in DATA, PARITY and STOP.
  - When it reaches TIMEOUT_CYCLES-1: frame_error pulse, → IDLE, shift register and bit_cnt cleared.
  - No timeout in IDLE.
- Accept timing: stop-bit fe detected in cycle N → in cycle N+1, byte_out is updated and byte_valid=1 for exactly one cycle.
- key_code update, same cycle as byte_valid, using the break_pending flag:
  - byte==F0 → break_pending=1, key_code unchanged.
  - byte==E0 → ignored, no flag change, key_code unchanged.
  - break_pending=1 and byte==key_code → key_code=0x00, break_pending=0.
  - break_pending=1 and byte!=key_code → key_code unchanged, break_pending=0.
  - Otherwise (make code) → key_code=byte; typematic repeats rewrite the same value.
- Simultaneous events: a fe in the same cycle the timeout fires is ignored (abort wins).
- frame_error and byte_valid are never both high in the same cycle.
- Reset, at any time including mid-frame:
  - state=IDLE, bit_cnt=0, shift=0, break_pending=0, timeout counter=0.
  - Filtered clock and both sync flops set to 1.
  - byte_out=0x00, key_code=0x00, byte_valid=0, frame_error=0.

Optional Feature:
- PS2_PARITY_CHECK_EN defined:
  - In STOP with stop=1, the frame is accepted only if popcount(d0..d7)+parity is odd.
  - Otherwise frame_error pulses in cycle N+1, with no byte_valid, and key_code/break_pending unchanged.
- Not defined: the parity bit is sampled but ignored, and every frame with stop=1 is accepted.

Test Plan:
- Bench config for all scenarios: FILTER_LEN=4, TIMEOUT_CYCLES=2000, ps2_clk half-period 100 clk cycles.
- Frame 0x1D, parity 1, stop 1 → byte_valid high 1 cycle, byte_out=0x1D, key_code=0x1D, frame_error stays 0.
- With key_code=0x1D: send F0 then 1D → after F0, key_code=0x1D with byte_out=0xF0; after 1D, key_code=0x00.
- With key_code=0x1D: send F0, 1B → key_code stays 0x1D. Then send E0 → byte_valid pulses, key_code still 0x1D.
- Frame 0x1B with parity 0 (even count) → with PS2_PARITY_CHECK_EN: frame_error 1 cycle, no byte_valid, key_code unchanged. Without the macro: byte_valid, key_code=0x1B.
- Start bit plus 3 data bits, then ps2_clk held high for 2000 cycles → one frame_error pulse, FSM in IDLE. Next clean frame 0x1B → key_code=0x1B.
- 2-cycle low glitch on ps2_clk in IDLE → no fe, no outputs.
- reset asserted for 1 cycle mid-frame, after 5 bits → all outputs 0. Next full 0x1D frame → accepted.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the pins, deframes scan codes and tracks the held key.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity_bit, parity_n;
  logic          break_pending;
  logic          fe, timeout_hit, parity_ok, accept, err;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      data_s1   <= ps2_data;
      data_s2   <= data_s1;
      filt_prev <= filt_clk;
      // A new level must persist FILTER_LEN samples before the filtered clock follows it
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fe          = filt_prev & ~filt_clk;
  assign timeout_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    parity_n  = parity_bit;
    accept    = 1'b0;
    err       = 1'b0;
    // Abort takes priority over any edge arriving in the same cycle
    if (timeout_hit) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      shift_n   = '0;
      err       = 1'b1;
    end else if (fe) begin
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            shift_n   = '0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          shift_n[bit_cnt] = data_s2;
          bit_cnt_n        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          parity_n = data_s2;
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (data_s2 && parity_ok) accept = 1'b1;
          else                      err    = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      parity_bit <= parity_n;
      if (timeout_hit || fe || state == IDLE) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 1'b1;
    end
  end

  // Held-key tracking: F0 arms a break, the next byte releases the key only if it matches
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_out      <= 8'h00;
      byte_valid    <= 1'b0;
      key_code      <= 8'h00;
      break_pending <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      byte_valid  <= accept;
      frame_error <= err;
      if (accept) begin
        byte_out <= shift;
        if (shift == 8'hF0) begin
          break_pending <= 1'b1;
        end else if (shift == 8'hE0) begin
          break_pending <= break_pending;
        end else if (break_pending) begin
          if (shift == key_code) key_code <= 8'h00;
          break_pending <= 1'b0;
        end else begin
          key_code <= shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: bit-bangs PS/2 frames and checks bytes, held key and error pulses.
module tb_ps2_scancode_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] key_code;
  logic       frame_error;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0;

  ps2_scancode_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .key_code(key_code),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (byte_valid) valid_cnt++;
      if (frame_error) err_cnt++;
      if (byte_valid && frame_error) both_cnt++;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nbits bits of a frame (start, d0..d7, parity, stop); clock idles high after
  task automatic applyStimulus(input logic [7:0] data, input logic par, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, par, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      waitCycles(100);
      ps2_clk = 1'b0;
      waitCycles(100);
      ps2_clk = 1'b1;
    end
    waitCycles(100);
    ps2_data = 1'b1;
  endtask

  task automatic sendAndCount(input logic [7:0] data, input logic par);
    v0 = valid_cnt;
    e0 = err_cnt;
    applyStimulus(data, par, 11);
  endtask

  initial begin
    waitCycles(5);
    checkOutput("reset byte_out", {24'd0, byte_out}, 32'h00);
    checkOutput("reset key_code", {24'd0, key_code}, 32'h00);
    checkOutput("reset byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("reset frame_error", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    waitCycles(20);

    sendAndCount(8'h1D, 1'b1);
    checkOutput("make 1D valid pulses", valid_cnt - v0, 1);
    checkOutput("make 1D no error", err_cnt - e0, 0);
    checkOutput("make 1D byte_out", {24'd0, byte_out}, 32'h1D);
    checkOutput("make 1D key_code", {24'd0, key_code}, 32'h1D);

    sendAndCount(8'hF0, 1'b1);
    checkOutput("break F0 byte_out", {24'd0, byte_out}, 32'hF0);
    checkOutput("break F0 key_code", {24'd0, key_code}, 32'h1D);
    sendAndCount(8'h1D, 1'b1);
    checkOutput("break 1D key_code", {24'd0, key_code}, 32'h00);

    sendAndCount(8'h1D, 1'b1);
    checkOutput("remake 1D key_code", {24'd0, key_code}, 32'h1D);
    sendAndCount(8'hF0, 1'b1);
    sendAndCount(8'h1B, 1'b1);
    checkOutput("mismatch break key_code", {24'd0, key_code}, 32'h1D);
    checkOutput("mismatch break byte_out", {24'd0, byte_out}, 32'h1B);
    sendAndCount(8'hE0, 1'b0);
    checkOutput("E0 valid pulses", valid_cnt - v0, 1);
    checkOutput("E0 byte_out", {24'd0, byte_out}, 32'hE0);
    checkOutput("E0 key_code", {24'd0, key_code}, 32'h1D);

    sendAndCount(8'h1B, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("bad parity error pulses", err_cnt - e0, 1);
    checkOutput("bad parity valid pulses", valid_cnt - v0, 0);
    checkOutput("bad parity key_code", {24'd0, key_code}, 32'h1D);
`else
    checkOutput("ignored parity error pulses", err_cnt - e0, 0);
    checkOutput("ignored parity valid pulses", valid_cnt - v0, 1);
    checkOutput("ignored parity key_code", {24'd0, key_code}, 32'h1B);
`endif

    v0 = valid_cnt;
    e0 = err_cnt;
    applyStimulus(8'h1D, 1'b1, 4);
    waitCycles(2200);
    checkOutput("timeout error pulses", err_cnt - e0, 1);
    checkOutput("timeout valid pulses", valid_cnt - v0, 0);
    sendAndCount(8'h1B, 1'b1);
    checkOutput("post-timeout valid", valid_cnt - v0, 1);
    checkOutput("post-timeout byte_out", {24'd0, byte_out}, 32'h1B);
    checkOutput("post-timeout key_code", {24'd0, key_code}, 32'h1B);

    v0 = valid_cnt;
    e0 = err_cnt;
    ps2_clk = 1'b0;
    waitCycles(2);
    ps2_clk = 1'b1;
    waitCycles(50);
    checkOutput("glitch error pulses", err_cnt - e0, 0);
    checkOutput("glitch valid pulses", valid_cnt - v0, 0);

    applyStimulus(8'h1D, 1'b1, 5);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("midframe reset byte_out", {24'd0, byte_out}, 32'h00);
    checkOutput("midframe reset key_code", {24'd0, key_code}, 32'h00);
    checkOutput("midframe reset byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("midframe reset frame_error", {31'd0, frame_error}, 32'd0);
    waitCycles(50);
    sendAndCount(8'h1D, 1'b1);
    checkOutput("post-reset valid", valid_cnt - v0, 1);
    checkOutput("post-reset error", err_cnt - e0, 0);
    checkOutput("post-reset key_code", {24'd0, key_code}, 32'h1D);

    checkOutput("valid and error overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
